iter_div: RTL

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/iter_div.sv
// Iterative restoring radix-2 divider, signed or unsigned, one quotient bit per cycle.
// Trivial operands (divide-by-zero, |x| < |y|) can skip the iteration when EARLY_OUT is set.
module iter_div #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               in_ready_r;
  logic               out_valid_r;

  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic               signed_r;

  logic               q_neg_r;
  logic               r_neg_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   ay_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH:0]     rem_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [WIDTH-1:0]   s_r;
  logic [WIDTH-1:0]   r_r;
  logic               dbz_out_r;

  logic               accept_s;
  logic [WIDTH-1:0]   ax_s;
  logic [WIDTH-1:0]   ay_s;
  logic               y_zero_s;
  logic               early_s;
  logic [WIDTH+1:0]   shift_s;
  logic [WIDTH+1:0]   diff_s;
  logic               qbit_s;
  logic               last_step_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic use_sign);
    if (use_sign && v[WIDTH-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // A cancel in the accept cycle wins, so the request is never taken.
  assign accept_s    = in_valid && in_ready_r && !cancel;
  assign ax_s        = magnitude(x_r, signed_r);
  assign ay_s        = magnitude(y_r, signed_r);
  assign y_zero_s    = (y_r == {WIDTH{1'b0}});
  assign early_s     = (EARLY_OUT != 0) && (y_zero_s || (ax_s < ay_s));
  assign shift_s     = {rem_r, quo_r[WIDTH-1]};
  assign diff_s      = shift_s - {2'b00, ay_r};
  assign qbit_s      = ~diff_s[WIDTH+1];
  assign last_step_s = (cnt_r == {CNT_W{1'b0}});

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = PREP;
        else          state_s = IDLE;
      end
      PREP: begin
        if (cancel)       state_s = IDLE;
        else if (early_s) state_s = FIX;
        else              state_s = CALC;
      end
      CALC: begin
        if (cancel)           state_s = IDLE;
        else if (last_step_s) state_s = FIX;
        else                  state_s = CALC;
      end
      FIX: begin
        if (cancel) state_s = IDLE;
        else        state_s = DONE;
      end
      DONE: begin
        if (cancel || out_ready) state_s = IDLE;
        else                     state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture on accept.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      signed_r <= 1'b0;
    end else if (accept_s) begin
      x_r      <= x;
      y_r      <= y;
      signed_r <= div_signed;
    end else begin
      x_r      <= x_r;
      y_r      <= y_r;
      signed_r <= signed_r;
    end
  end

  // Iteration datapath: magnitudes and signs in PREP, one restoring step per CALC cycle.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      dbz_r   <= 1'b0;
      ay_r    <= {WIDTH{1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      rem_r   <= {(WIDTH+1){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        PREP: begin
          q_neg_r <= signed_r & (x_r[WIDTH-1] ^ y_r[WIDTH-1]);
          r_neg_r <= signed_r & x_r[WIDTH-1];
          dbz_r   <= y_zero_s;
          ay_r    <= ay_s;
          cnt_r   <= CNT_W'(WIDTH - 1);
          // Early-out leaves the quotient at zero and the whole dividend as remainder.
          if (early_s) begin
            quo_r <= {WIDTH{1'b0}};
            rem_r <= {1'b0, ax_s};
          end else begin
            quo_r <= ax_s;
            rem_r <= {(WIDTH+1){1'b0}};
          end
        end
        CALC: begin
          cnt_r <= cnt_r - CNT_W'(1'b1);
          quo_r <= {quo_r[WIDTH-2:0], qbit_s};
          if (qbit_s) rem_r <= diff_s[WIDTH:0];
          else        rem_r <= shift_s[WIDTH:0];
        end
        default: begin
          cnt_r <= cnt_r;
          quo_r <= quo_r;
          rem_r <= rem_r;
        end
      endcase
    end
  end

  // Result registers, loaded in FIX and held through DONE.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      s_r       <= {WIDTH{1'b0}};
      r_r       <= {WIDTH{1'b0}};
      dbz_out_r <= 1'b0;
    end else if (state_r == FIX) begin
      dbz_out_r <= dbz_r;
      if (dbz_r) begin
        s_r <= {WIDTH{1'b1}};
        r_r <= x_r;
      end else begin
        s_r <= q_neg_r ? -quo_r : quo_r;
        r_r <= r_neg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
      end
    end else begin
      s_r       <= s_r;
      r_r       <= r_r;
      dbz_out_r <= dbz_out_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign s           = s_r;
  assign r           = r_r;
  assign div_by_zero = dbz_out_r;

endmodule
